// File: rtl/id_pipe_stage.sv
// id_pipe_stage -- instruction-decode stage of a 5-stage LEGv8-style pipeline.
//
// Holds the 2**AREG_W x DATA_W register file (highest index is XZR, reads as 0,
// writes discarded). Also produces the sign-extended immediate and detects
// load-use hazards, and registers everything into the ID/EX pipeline register.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   valid_in               decoded instruction present in ID
//   Rn, Rm, Rd, Reg2Loc    source/destination addresses, port-B select (1=Rm, 0=Rd)
//   reads_a, reads_b       instruction consumes port A / port B
//   is_load                instruction is a load
//   imm_raw, imm_sel       raw immediate bits and field select
//   flush                  squash the instruction in ID
//   wb_en/wb_addr/wb_data  write-back port (bypassed to same-cycle reads)
//   stall                  combinational load-use stall to upstream
//   ex_*                   registered ID/EX outputs
module id_pipe_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [AREG_W-1:0] Rn,
  input  logic [AREG_W-1:0] Rm,
  input  logic [AREG_W-1:0] Rd,
  input  logic              Reg2Loc,
  input  logic              reads_a,
  input  logic              reads_b,
  input  logic              is_load,
  input  logic [25:0]       imm_raw,
  input  logic [1:0]        imm_sel,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AREG_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_is_load,
  output logic [DATA_W-1:0] ex_Da,
  output logic [DATA_W-1:0] ex_Db,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AREG_W-1:0] ex_Rd,
  output logic [AREG_W-1:0] ex_Ab
);

  localparam int unsigned       NREGS = 2 ** AREG_W;
  localparam logic [AREG_W-1:0] XZR   = '1;

  logic [DATA_W-1:0] rf [NREGS];
  logic [AREG_W-1:0] ab;
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] db;
  logic [DATA_W-1:0] imm;
  logic              wb_live;
  logic              bubble;

  assign ab      = Reg2Loc ? Rm : Rd;
  assign wb_live = wb_en && (wb_addr != XZR);

  // Register file: XZR is never written, so its storage stays at the reset 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Read ports with write-before-read bypass; XZR check last so it always wins.
  always_comb begin
    da = rf[Rn];
    if (wb_live && (wb_addr == Rn)) da = wb_data;
    if (Rn == XZR) da = '0;
  end

  always_comb begin
    db = rf[ab];
    if (wb_live && (wb_addr == ab)) db = wb_data;
    if (ab == XZR) db = '0;
  end

  always_comb begin
    imm = '0;
    case (imm_sel)
      2'b00:   imm = {{(DATA_W-12){imm_raw[21]}}, imm_raw[21:10]};
      2'b01:   imm = {{(DATA_W-9){imm_raw[20]}},  imm_raw[20:12]};
      2'b10:   imm = {{(DATA_W-19){imm_raw[23]}}, imm_raw[23:5]};
      default: imm = {{(DATA_W-26){imm_raw[25]}}, imm_raw[25:0]};
    endcase
  end

  // The bubble inserted on a stall clears ex_is_load, so a stall self-terminates
  // after one cycle.
  assign stall = !flush && valid_in && ex_valid && ex_is_load && (ex_Rd != XZR) &&
                 ((reads_a && (Rn == ex_Rd)) || (reads_b && (ab == ex_Rd)));

  assign bubble = flush || stall || !valid_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_Da      <= '0;
      ex_Db      <= '0;
      ex_imm     <= '0;
      ex_Rd      <= XZR;
      ex_Ab      <= XZR;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_is_load <= is_load;
      ex_Da      <= da;
      ex_Db      <= db;
      ex_imm     <= imm;
      ex_Rd      <= Rd;
      ex_Ab      <= ab;
    end
  end

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64, datapath and register width.
REQ-002 Parameter AREG_W, default 5, register address width (2**AREG_W registers; highest index is the zero register XZR).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid_in  in  1  decoded instruction present in ID this cycle.
REQ-006 Rn, Rm, Rd  in  AREG_W each  source A, source B, destination addresses.
REQ-007 Reg2Loc  in  1  port-B address select: 1 = Rm, 0 = Rd.
REQ-008 reads_a, reads_b  in  1 each  instruction consumes port A / port B.
REQ-009 is_load  in  1  instruction is a load (LDUR).
REQ-010 imm_raw  in  26  instruction immediate bits [25:0].
REQ-011 imm_sel  in  2  00 ALU_imm12 = imm_raw[21:10], 01 DT_addr9 = imm_raw[20:12], 10 COND_BR19 = imm_raw[23:5], 11 BR26 = imm_raw[25:0].
REQ-012 flush  in  1  squash the instruction currently in ID (taken branch).
REQ-013 wb_en, wb_addr, wb_data  in  1 / AREG_W / DATA_W  write-back port.
REQ-014 stall  out  1  combinational; upstream holds PC and IF/ID when 1.
REQ-015 ex_valid, ex_is_load  out  1 each  registered ID/EX outputs.
REQ-016 ex_Da, ex_Db, ex_imm  out  DATA_W each  registered operands and sign-extended immediate.
REQ-017 ex_Rd, ex_Ab  out  AREG_W each  registered destination and resolved port-B address.

Function
REQ-018 Ab = Reg2Loc ? Rm : Rd; Da reads Rn, Db reads Ab, both combinational.
REQ-019 Register file shall write wb_data to wb_addr on the rising edge when wb_en=1 and wb_addr != XZR.
REQ-020 Reads of XZR shall return 0; writes to XZR shall be discarded.
REQ-021 Same-cycle bypass: a read whose address equals wb_addr with wb_en=1 and wb_addr != XZR shall return wb_data (write-before-read).
REQ-022 Selected immediate field shall be sign-extended from its MSB to DATA_W.
REQ-023 stall = valid_in & ex_valid & ex_is_load & ex_Rd != XZR & ((reads_a & Rn == ex_Rd) | (reads_b & Ab == ex_Rd)), forced 0 when flush=1.
REQ-024 Each rising edge: if flush or stall or !valid_in, ex_valid <= 0 (bubble), else ex_valid <= 1 and all ex_* capture current ID values; latency ID->EX is one cycle.
REQ-025 During a bubble, ex_Da/ex_Db/ex_imm/ex_Rd/ex_Ab may hold stale values but ex_is_load shall be 0.
REQ-026 flush has priority over stall; a stall lasts exactly one cycle per load-use pair, as the bubble clears the ex_is_load condition.
REQ-027 Simultaneous wb write and ID read of the same register shall use the REQ-021 bypass with no stall.

Reset
REQ-028 While reset=1 on a rising edge: all 2**AREG_W registers <= 0, ex_valid <= 0, ex_is_load <= 0, ex_Da/ex_Db/ex_imm <= 0, ex_Rd/ex_Ab <= XZR.
REQ-029 reset shall override wb_en, flush, and valid_in in the same cycle; stall shall read 0 in the first cycle after reset.

Verification
REQ-030 Write X8=69 (wb_en=1), next cycle Rn=Rm=8, Reg2Loc=1, valid_in=1 -> one edge later ex_Da=ex_Db=69, ex_valid=1.
REQ-031 wb_en=1, wb_addr=3, wb_data=0xDEAD while Rn=3 in same cycle -> ex_Da=0xDEAD next edge, stall=0.
REQ-032 Write XZR=5, then read Rn=31 -> ex_Da=0.
REQ-033 LDUR X2 in EX (ex_is_load=1, ex_Rd=2), ID ADD with Rn=2, reads_a=1 -> stall=1 for one cycle, ex_valid=0 next edge, then ADD issues with ex_valid=1.
REQ-034 imm_sel=10, imm_raw[23:5]=19'h7FFFF -> ex_imm=all ones; imm_sel=00, imm_raw[21:10]=12'h7FF -> ex_imm=0x7FF.
REQ-035 flush=1 coincident with a load-use stall -> stall=0, ex_valid=0 next edge; reset asserted mid-stream -> all outputs per REQ-028 after one edge.
